// File: rtl/drm_stream_arbiter_if.sv
// Stream bundle around drm_stream_arbiter: activator upstream/downstream ports and the controller channel pair.
// slave = arbiter view, master = environment view (activators plus DRM Controller).
interface drm_stream_arbiter_if #(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]    s_uip_to_drm_tvalid;
  logic [N_PORTS-1:0]    s_uip_to_drm_tready;
  logic [N_PORTS-1:0]    s_uip_to_drm_tlast;
  logic [32*N_PORTS-1:0] s_uip_to_drm_tdata;

  logic                  m_uip_to_drm_tvalid;
  logic                  m_uip_to_drm_tready;
  logic                  m_uip_to_drm_tlast;
  logic [31:0]           m_uip_to_drm_tdata;

  logic                  s_drm_to_uip_tvalid;
  logic                  s_drm_to_uip_tready;
  logic                  s_drm_to_uip_tlast;
  logic [31:0]           s_drm_to_uip_tdata;

  logic [N_PORTS-1:0]    m_drm_to_uip_tvalid;
  logic [N_PORTS-1:0]    m_drm_to_uip_tready;
  logic                  m_drm_to_uip_tlast;
  logic [31:0]           m_drm_to_uip_tdata;

  modport slave (
    input  s_uip_to_drm_tvalid, s_uip_to_drm_tdata, s_uip_to_drm_tlast,
    output s_uip_to_drm_tready,
    output m_uip_to_drm_tvalid, m_uip_to_drm_tdata, m_uip_to_drm_tlast,
    input  m_uip_to_drm_tready,
    input  s_drm_to_uip_tvalid, s_drm_to_uip_tdata, s_drm_to_uip_tlast,
    output s_drm_to_uip_tready,
    output m_drm_to_uip_tvalid, m_drm_to_uip_tdata, m_drm_to_uip_tlast,
    input  m_drm_to_uip_tready
  );

  modport master (
    output s_uip_to_drm_tvalid, s_uip_to_drm_tdata, s_uip_to_drm_tlast,
    input  s_uip_to_drm_tready,
    input  m_uip_to_drm_tvalid, m_uip_to_drm_tdata, m_uip_to_drm_tlast,
    output m_uip_to_drm_tready,
    output s_drm_to_uip_tvalid, s_drm_to_uip_tdata, s_drm_to_uip_tlast,
    input  s_drm_to_uip_tready,
    input  m_drm_to_uip_tvalid, m_drm_to_uip_tdata, m_drm_to_uip_tlast,
    output m_drm_to_uip_tready
  );
endinterface

// File: rtl/drm_stream_arbiter.sv
// Shares one DRM Controller stream pair between N_PORTS activators: packet round-robin upstream, broadcast downstream.
// Optional DRM_ARB_OUTPUT_REG_EN inserts a 2-entry skid buffer on the controller-bound output.
module drm_stream_arbiter #(
  parameter int N_PORTS = 2
) (
  input  logic                drm_aclk,
  input  logic                drm_arstn,
  drm_stream_arbiter_if.slave bus,
  output logic [N_PORTS-1:0]  grant,
  output logic                busy
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, GNT} state_t;

  state_t             state_reg, state_next;
  logic [N_PORTS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;

  logic [31:0]        up_data [N_PORTS];
  logic [N_PORTS-1:0] up_ready;
  logic               in_valid, in_ready, in_last, in_hs;
  logic [31:0]        in_data;

  logic [N_PORTS-1:0] acked_reg, acked_next;
  logic [N_PORTS-1:0] dn_valid, dn_pass, dn_hs;
  logic               dn_done;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_up
      assign up_data[gi]  = bus.s_uip_to_drm_tdata[32*gi +: 32];
      assign up_ready[gi] = grant_reg[gi] & in_ready;
    end
  endgenerate

  // grant_reg is zero in IDLE, so nothing reaches the output stage outside GNT
  assign in_valid = |(grant_reg & bus.s_uip_to_drm_tvalid);
  assign in_data  = up_data[owner_reg];
  assign in_last  = bus.s_uip_to_drm_tlast[owner_reg];
  assign in_hs    = in_valid & in_ready;

  assign bus.s_uip_to_drm_tready = up_ready;
  assign grant = grant_reg;
  assign busy  = (state_reg == GNT);

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      automatic int cand = int'(last_reg) + k;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      if (!sel_found && bus.s_uip_to_drm_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      last_reg  <= IDX_W'(N_PORTS - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next          = GNT;
          owner_next          = sel_idx;
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
        end
      end
      GNT: begin
        // release only on the owner's accepted tlast beat; no timeout
        if (in_hs && in_last) begin
          state_next = IDLE;
          grant_next = '0;
          last_next  = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DRM_ARB_OUTPUT_REG_EN
  logic        out_valid_reg, skid_valid_reg;
  logic        out_last_reg, skid_last_reg;
  logic [31:0] out_data_reg, skid_data_reg;

  // skid register empty == buffer not full; input ready is a pure flop output
  assign in_ready = ~skid_valid_reg;

  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
    end else if (skid_valid_reg) begin
      if (bus.m_uip_to_drm_tready) begin
        out_data_reg   <= skid_data_reg;
        out_last_reg   <= skid_last_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (in_hs) begin
      if (!out_valid_reg || bus.m_uip_to_drm_tready) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data;
        out_last_reg  <= in_last;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= in_data;
        skid_last_reg  <= in_last;
      end
    end else if (bus.m_uip_to_drm_tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.m_uip_to_drm_tvalid = out_valid_reg;
  assign bus.m_uip_to_drm_tdata  = out_data_reg;
  assign bus.m_uip_to_drm_tlast  = out_last_reg;
`else
  assign in_ready                = bus.m_uip_to_drm_tready;
  assign bus.m_uip_to_drm_tvalid = in_valid;
  assign bus.m_uip_to_drm_tdata  = in_data;
  assign bus.m_uip_to_drm_tlast  = in_last;
`endif

  // Downstream broadcast: a port that already took the current beat is masked until all ports have it
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_dn
      assign dn_valid[gi]   = bus.s_drm_to_uip_tvalid & ~acked_reg[gi];
      assign dn_pass[gi]    = bus.m_drm_to_uip_tready[gi] | acked_reg[gi];
      assign dn_hs[gi]      = dn_valid[gi] & bus.m_drm_to_uip_tready[gi];
      assign acked_next[gi] = dn_done ? 1'b0 : (acked_reg[gi] | dn_hs[gi]);
    end
  endgenerate

  assign bus.s_drm_to_uip_tready = &dn_pass;
  assign dn_done                 = bus.s_drm_to_uip_tvalid & bus.s_drm_to_uip_tready;
  assign bus.m_drm_to_uip_tvalid = dn_valid;
  assign bus.m_drm_to_uip_tdata  = bus.s_drm_to_uip_tdata;
  assign bus.m_drm_to_uip_tlast  = bus.s_drm_to_uip_tlast;

  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      acked_reg <= '0;
    end else begin
      acked_reg <= acked_next;
    end
  end
endmodule

// File: tb/tb_drm_stream_arbiter.sv
// Randomized bench for drm_stream_arbiter: packet-level round-robin model upstream, per-port delivery model downstream.
module tb_drm_stream_arbiter;
  localparam int N = 3;
`ifdef DRM_ARB_OUTPUT_REG_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        first;
    logic [7:0]  port;
  } beat_t;

  logic         drm_aclk = 1'b0;
  logic         drm_arstn;
  logic [N-1:0] grant;
  logic         busy;

  drm_stream_arbiter_if #(.N_PORTS(N)) bus ();

  drm_stream_arbiter #(.N_PORTS(N)) dut (
    .drm_aclk (drm_aclk),
    .drm_arstn(drm_arstn),
    .bus      (bus),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 drm_aclk = ~drm_aclk;

  beat_t        pq [N][$];
  beat_t        exp_q [$];
  int           model_last;
  int           checks   = 0;
  int           failures = 0;
  int           out_cyc [$];
  logic [N-1:0] grant_log [$];
  logic         busy_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add_packet(input int p, input int nbeats, input logic [31:0] base);
    for (int k = 0; k < nbeats; k++) begin
      beat_t b;
      b.data  = base + k;
      b.first = (k == 0);
      b.last  = (k == nbeats - 1);
      b.port  = 8'(p);
      pq[p].push_back(b);
    end
  endtask

  // Every port with queued packets requests continuously, so service order is plain round-robin over non-empty ports.
  task automatic build_expected();
    beat_t tmp [N][$];
    bit    any;
    for (int i = 0; i < N; i++) tmp[i] = pq[i];
    exp_q.delete();
    do begin
      any = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (model_last + k) % N;
        if (!any && tmp[idx].size() > 0) begin
          beat_t b;
          any = 1;
          do begin
            b = tmp[idx].pop_front();
            exp_q.push_back(b);
          end while (!b.last);
          model_last = idx;
        end
      end
    end while (any);
  endtask

  task automatic drive_up_idle();
    bus.s_uip_to_drm_tvalid = '0;
    bus.s_uip_to_drm_tdata  = '0;
    bus.s_uip_to_drm_tlast  = '0;
    bus.m_uip_to_drm_tready = 1'b1;
  endtask

  task automatic do_reset();
    drm_arstn = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    model_last = N - 1;
    drive_up_idle();
    repeat (2) @(posedge drm_aclk);
    #1 drm_arstn = 1'b1;
  endtask

  // mode 0: sink always ready; 1: random gaps and random sink ready; 2: sink ready toggles 1,0,1,0
  task automatic run_up(input int max_cyc, input int mode, output int cyc);
    build_expected();
    out_cyc.delete();
    grant_log.delete();
    busy_log.delete();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() > 0) begin
          bus.s_uip_to_drm_tvalid[i]         = pq[i][0].first || (mode != 1) || ($urandom_range(3) != 0);
          bus.s_uip_to_drm_tdata[32*i +: 32] = pq[i][0].data;
          bus.s_uip_to_drm_tlast[i]          = pq[i][0].last;
        end else begin
          bus.s_uip_to_drm_tvalid[i]         = 1'b0;
          bus.s_uip_to_drm_tdata[32*i +: 32] = '0;
          bus.s_uip_to_drm_tlast[i]          = 1'b0;
        end
      end
      case (mode)
        1:       bus.m_uip_to_drm_tready = ($urandom_range(2) != 0);
        2:       bus.m_uip_to_drm_tready = ((cyc % 2) == 0);
        default: bus.m_uip_to_drm_tready = 1'b1;
      endcase
      @(negedge drm_aclk);
      grant_log.push_back(grant);
      busy_log.push_back(busy);
      check("ready_onehot0", 32'($onehot0(bus.s_uip_to_drm_tready)), 1);
      if (!busy) check("idle_grant", 32'(grant), 0);
`ifndef DRM_ARB_OUTPUT_REG_EN
      if (busy && exp_q.size() > 0) check("grant_owner", 32'(grant), 32'(1) << exp_q[0].port);
`endif
      if (bus.m_uip_to_drm_tvalid && bus.m_uip_to_drm_tready) begin
        check("up_data", bus.m_uip_to_drm_tdata, exp_q[0].data);
        check("up_last", 32'(bus.m_uip_to_drm_tlast), 32'(exp_q[0].last));
        if (exp_q[0].last) $display("upstream packet from port %0d delivered at cycle %0d", exp_q[0].port, cyc);
        out_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < N; i++)
        if (bus.s_uip_to_drm_tvalid[i] && bus.s_uip_to_drm_tready[i] && pq[i].size() > 0)
          void'(pq[i].pop_front());
      cyc++;
      @(posedge drm_aclk);
      #1;
    end
    check("up_drained", exp_q.size(), 0);
    for (int i = 0; i < N; i++) pq[i].delete();
    drive_up_idle();
  endtask

  task automatic run_down(input int nbeats);
    logic [31:0] beats [$];
    int          recv [N];
    int          sent;
    int          cyc;
    sent = 0;
    cyc  = 0;
    for (int k = 0; k < nbeats; k++) beats.push_back($urandom);
    for (int i = 0; i < N; i++) recv[i] = 0;
    while (sent < nbeats && cyc < 3000) begin
      bus.s_drm_to_uip_tvalid = ($urandom_range(3) != 0);
      bus.s_drm_to_uip_tdata  = beats[sent];
      bus.s_drm_to_uip_tlast  = ((sent % 4) == 3);
      for (int i = 0; i < N; i++) bus.m_drm_to_uip_tready[i] = ($urandom_range(1) != 0);
      @(negedge drm_aclk);
      for (int i = 0; i < N; i++) begin
        if (bus.m_drm_to_uip_tvalid[i] && bus.m_drm_to_uip_tready[i]) begin
          if (recv[i] < nbeats) begin
            check("dn_data", bus.m_drm_to_uip_tdata, beats[recv[i]]);
            check("dn_last", 32'(bus.m_drm_to_uip_tlast), 32'((recv[i] % 4) == 3));
          end
          recv[i]++;
        end
      end
      if (bus.s_drm_to_uip_tvalid && bus.s_drm_to_uip_tready) begin
        for (int i = 0; i < N; i++) check("dn_once", recv[i], sent + 1);
        $display("downstream beat %0d 0x%08h delivered to all ports", sent, beats[sent]);
        sent++;
      end
      cyc++;
      @(posedge drm_aclk);
      #1;
    end
    bus.s_drm_to_uip_tvalid = 1'b0;
    bus.m_drm_to_uip_tready = '0;
    for (int i = 0; i < N; i++) check("dn_count", recv[i], nbeats);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n_out;
    int cnt [N];
    bit done;

    // reset state with requests and controller data already present
    drm_arstn               = 1'b0;
    model_last              = N - 1;
    bus.s_uip_to_drm_tvalid = '1;
    bus.s_uip_to_drm_tdata  = '0;
    bus.s_uip_to_drm_tlast  = '0;
    bus.m_uip_to_drm_tready = 1'b1;
    bus.s_drm_to_uip_tvalid = 1'b1;
    bus.s_drm_to_uip_tdata  = 32'h5555_AAAA;
    bus.s_drm_to_uip_tlast  = 1'b0;
    bus.m_drm_to_uip_tready = '0;
    repeat (2) @(negedge drm_aclk);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_m_tvalid", 32'(bus.m_uip_to_drm_tvalid), 0);
    check("rst_s_tready", 32'(bus.s_uip_to_drm_tready), 0);
    check("rst_dn_tvalid", 32'(bus.m_drm_to_uip_tvalid), 32'((1 << N) - 1));
    check("rst_dn_tready", 32'(bus.s_drm_to_uip_tready), 0);
    bus.s_drm_to_uip_tvalid = 1'b0;
    do_reset();

    // single packet from port 0
    add_packet(0, 3, 32'hA0);
    run_up(50, 0, cyc);
    check("single_beats", out_cyc.size(), 3);
    for (int k = 0; k < 3 && k < out_cyc.size(); k++) check("single_cycle", out_cyc[k], 1 + L + k);
    check("single_idle0", 32'(busy_log[0]), 0);
    check("single_grant", 32'(grant_log[1]), 1);
    check("single_hold", 32'(grant_log[2]), 1);
    @(negedge drm_aclk);
    check("single_bubble", 32'(busy), 0);
    @(posedge drm_aclk);
    #1;

    // contention at reset release, then a repeat
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_packet(0, 2, 32'h1000 + 32'(r * 16));
      add_packet(1, 2, 32'h2000 + 32'(r * 16));
      run_up(50, 0, cyc);
      check("cont_cycles", cyc, 6 + L);
      check("cont_first", 32'(grant_log[1]), 1);
      check("cont_second", 32'(grant_log[4]), 2);
    end

    // backpressure with a pending competitor
    add_packet(0, 4, 32'h3000);
    add_packet(1, 2, 32'h4000);
    run_up(100, 2, cyc);

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < N; p++) begin
        int np;
        np = $urandom_range(3);
        for (int k = 0; k < np; k++) add_packet(p, 1 + $urandom_range(4), $urandom);
      end
      run_up(2000, 1, cyc);
    end

    // reset in the middle of a 4-beat packet
    add_packet(0, 4, 32'hC0);
    n_out = 0;
    cyc   = 0;
    while (n_out < 2 && cyc < 50) begin
      bus.s_uip_to_drm_tvalid[0] = (pq[0].size() > 0);
      bus.s_uip_to_drm_tdata[31:0] = (pq[0].size() > 0) ? pq[0][0].data : 32'h0;
      bus.s_uip_to_drm_tlast[0]  = (pq[0].size() > 0) ? pq[0][0].last : 1'b0;
      bus.m_uip_to_drm_tready    = 1'b1;
      @(negedge drm_aclk);
      if (bus.m_uip_to_drm_tvalid && bus.m_uip_to_drm_tready) n_out++;
      if (bus.s_uip_to_drm_tvalid[0] && bus.s_uip_to_drm_tready[0] && pq[0].size() > 0) void'(pq[0].pop_front());
      cyc++;
      @(posedge drm_aclk);
      #1;
    end
    check("mid_reach", n_out, 2);
    drm_arstn = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_grant", 32'(grant), 0);
    check("mid_m_tvalid", 32'(bus.m_uip_to_drm_tvalid), 0);
    check("mid_s_tready", 32'(bus.s_uip_to_drm_tready), 0);
    do_reset();
    add_packet(1, 2, 32'h6000);
    add_packet(0, 2, 32'h5000);
    run_up(50, 0, cyc);
    check("mid_after_first", 32'(grant_log[1]), 1);

    // downstream broadcast skew: ports ready at +0, +2, +5
    for (int i = 0; i < N; i++) cnt[i] = 0;
    done = 0;
    for (int c = 0; c < 8; c++) begin
      bus.s_drm_to_uip_tvalid    = !done;
      bus.s_drm_to_uip_tdata     = 32'h1234;
      bus.s_drm_to_uip_tlast     = 1'b1;
      bus.m_drm_to_uip_tready[0] = 1'b1;
      bus.m_drm_to_uip_tready[1] = (c >= 2);
      bus.m_drm_to_uip_tready[2] = (c >= 5);
      @(negedge drm_aclk);
      for (int i = 0; i < N; i++) begin
        if (bus.m_drm_to_uip_tvalid[i] && bus.m_drm_to_uip_tready[i]) begin
          cnt[i]++;
          check("skew_data", bus.m_drm_to_uip_tdata, 32'h1234);
        end
      end
      if (!done) check("skew_tready", 32'(bus.s_drm_to_uip_tready), 32'(c == 5));
      if (bus.s_drm_to_uip_tvalid && bus.s_drm_to_uip_tready) begin
        done = 1;
        $display("downstream skew beat 0x1234 completed at cycle +%0d", c);
      end
      @(posedge drm_aclk);
      #1;
    end
    for (int i = 0; i < N; i++) check("skew_count", cnt[i], 1);
    bus.s_drm_to_uip_tvalid = 1'b0;
    bus.m_drm_to_uip_tready = '0;

    run_down(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
